// File: rtl/program_counter_block.sv
// program_counter_block
//   Instruction-fetch front end. A 6-bit program counter walks a
//   word-addressed 32-bit instruction ROM. On every rising clock edge the
//   word at the current PC is registered onto n_instruction, and the PC
//   advances by one. The PC wraps from 2**PC_W-1 back to 0.
//
// Parameters
//   DATA_W     instruction width in bits
//   PC_W       program counter width; ROM depth is 2**PC_W words
//   INIT_FILE  ROM image name; the ROM is zeroed at time 0 and filled by benches
//
// Ports
//   clock          in   1       rising-edge system clock
//   n_instruction  out  DATA_W  registered fetched instruction
//   reset          in   1       asynchronous, active-high reset
module program_counter_block #(
  parameter int    DATA_W    = 32,
  parameter int    PC_W      = 6,
  parameter string INIT_FILE = ""
) (
  input  logic              clock,
  output logic [DATA_W-1:0] n_instruction,
  input  logic              reset
);

  localparam int DEPTH = 2 ** PC_W;

  logic [DATA_W-1:0] all_instruction [0:DEPTH-1];

  // The power-up values make the block behave as if reset were applied at
  // t=0, even when reset is never asserted.
  logic [DATA_W-1:0] new_instruction = '0;
  logic [PC_W-1:0]   program_c       = '0;

  // ROM contents. Words that are never loaded read as zero. Benches may
  // overwrite words at time 0.
  initial begin
    for (int i = 0; i < DEPTH; i++) all_instruction[i] = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      new_instruction <= '0;
      program_c       <= '0;
    end else begin
      new_instruction <= all_instruction[program_c];
      program_c       <= program_c + 1'b1;   // natural modulo-2**PC_W wrap
    end
  end

  // The output is a pure copy of the fetch register. There is no
  // combinational path from the PC.
  assign n_instruction = new_instruction;

endmodule

// File: tb/tb_program_counter_block.sv
module tb_program_counter_block;

  logic        clock  = 1'b0;
  logic        reset  = 1'b1;
  logic        reset2 = 1'b0;
  logic [31:0] n_instruction;
  logic [31:0] n_instruction2;

  int compared   = 0;
  int mismatched = 0;

  program_counter_block #(.DATA_W(32), .PC_W(6), .INIT_FILE("")) dut (
    .clock(clock), .n_instruction(n_instruction), .reset(reset));

  // The second instance is never loaded and never reset.
  program_counter_block #(.DATA_W(32), .PC_W(6), .INIT_FILE("")) dut2 (
    .clock(clock), .n_instruction(n_instruction2), .reset(reset2));

  always #5 clock = ~clock;

  int edges2 = 0;
  always @(posedge clock) edges2++;

  typedef struct {
    logic [5:0]  pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  logic [31:0] model_rom [0:63];
  logic [5:0]  model_pc;
  logic [31:0] model_out;

  typedef struct {
    logic        rst;
    int          n_edges;
    logic [5:0]  end_pc;
    logic [31:0] end_out;
  } step_t;
  step_t steps [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance the model and push its prediction, then wait for the edge and
  // compare the DUT against the popped prediction.
  task automatic edge_step();
    exp_t e;
    if (reset) begin
      model_pc  = 6'd0;
      model_out = 32'h0;
    end else begin
      model_out = model_rom[model_pc];
      model_pc  = model_pc + 6'd1;
    end
    e.pc = model_pc; e.instr = model_out;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("sb_instr", n_instruction, e.instr);
      check("sb_pc", {26'd0, dut.program_c}, {26'd0, e.pc});
    end
    check("noload_instr", n_instruction2, 32'h0);
    check("noload_pc", {26'd0, dut2.program_c}, edges2 & 32'h3f);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) model_rom[i] = (i < 24) ? 32'h100 + i : 32'h0;
    model_pc  = 6'd0;
    model_out = 32'h0;

    steps[0] = '{1'b1, 3,  6'd0,  32'h0};    // reset held across 3 edges
    steps[1] = '{1'b0, 1,  6'd1,  32'h100};  // first edge after release
    steps[2] = '{1'b0, 23, 6'd24, 32'h117};  // stops on program_c == 24
    steps[3] = '{1'b0, 40, 6'd0,  32'h0};    // edge 64: wrap, word 63 = 0
    steps[4] = '{1'b0, 1,  6'd1,  32'h100};  // edge 65 refetches word 0
    steps[5] = '{1'b0, 9,  6'd10, 32'h109};

    #1;
    for (int i = 0; i < 24; i++) dut.all_instruction[i] = 32'h100 + i;
    check("reset_instr", n_instruction, 32'h0);
    check("reset_pc", {26'd0, dut.program_c}, 32'd0);

    for (int s = 0; s < 6; s++) begin
      @(negedge clock);
      reset = steps[s].rst;
      for (int k = 0; k < steps[s].n_edges; k++) edge_step();
      check($sformatf("step%0d_end_pc", s), {26'd0, dut.program_c}, {26'd0, steps[s].end_pc});
      check($sformatf("step%0d_end_instr", s), n_instruction, steps[s].end_out);
    end

    // Asynchronous reset between edges, with program_c at 10.
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("async_rst_instr", n_instruction, 32'h0);
    check("async_rst_pc", {26'd0, dut.program_c}, 32'd0);
    for (int k = 0; k < 3; k++) edge_step();
    check("hold_rst_pc", {26'd0, dut.program_c}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    edge_step();
    check("post_rst_instr", n_instruction, 32'h100);
    check("post_rst_pc", {26'd0, dut.program_c}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
